// File: rtl/result_drain.sv
// Drains a row of PE accumulators: snapshots them on Capture, clears the array,
// then streams right-shifted, saturated elements over a valid/ready port.
module result_drain #(
  parameter int unsigned COLS              = 4,
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned ACCUMULATOR_WIDTH = 32
) (
  input  logic                                       CLK,
  input  logic                                       SYNC_RST,
  input  logic                                       Capture,
  input  logic [COLS*ACCUMULATOR_WIDTH-1:0]          Results,
  input  logic [$clog2(ACCUMULATOR_WIDTH)-1:0]       Shift,
  input  logic                                       OutReady,
  output logic                                       OutValid,
  output logic [WIDTH-1:0]                           OutData,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] OutIndex,
  output logic                                       OutLast,
  output logic                                       ArrayClear,
  output logic                                       Busy,
  output logic                                       Overrun
);

  localparam int unsigned ACCW = ACCUMULATOR_WIDTH;
  localparam int unsigned SHW  = $clog2(ACCUMULATOR_WIDTH);
  localparam int unsigned IDXW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ACCW-1:0] SAT_LIM = ACCW'((64'd1 << WIDTH) - 64'd1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [ACCW-1:0]   buf_q [COLS];
  logic [SHW-1:0]    shift_q, shift_d;
  logic [IDXW-1:0]   idx_q, idx_d, nxt_idx;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              last_q, last_d;
  logic              clear_q, clear_d;
  logic              overrun_q, overrun_d;
  logic              hs, accept;

  // Logical right shift followed by unsigned saturation to WIDTH bits.
  function automatic logic [WIDTH-1:0] requant(input logic [ACCW-1:0] v,
                                               input logic [SHW-1:0]  sh);
    logic [ACCW-1:0] s;
    s = v >> sh;
    if (s > SAT_LIM) return '1;
    return s[WIDTH-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      clear_q   <= clear_d;
      overrun_q <= overrun_d;
    end
  end

  // Shadow copy of the accumulators; contents are meaningless until a capture.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        buf_q[c] <= Results[c*ACCW +: ACCW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    clear_d   = 1'b0;
    nxt_idx   = idx_q + IDXW'(1);
    hs        = (state_q == STREAM) && OutReady;
    // A capture landing on the final handshake chains straight into the next tile.
    accept    = Capture && ((state_q == IDLE) || (hs && last_q));
    overrun_d = overrun_q || (Capture && !accept);

    if (accept) begin
      state_d = STREAM;
      shift_d = Shift;
      idx_d   = '0;
      data_d  = requant(Results[ACCW-1:0], Shift);
      last_d  = (COLS == 1);
      clear_d = 1'b1;
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        idx_d  = nxt_idx;
        data_d = requant(buf_q[nxt_idx], shift_q);
        last_d = (nxt_idx == LAST_IDX);
      end
    end
  end

  assign OutValid   = (state_q == STREAM);
  assign Busy       = (state_q == STREAM);
  assign OutData    = data_q;
  assign OutIndex   = idx_q;
  assign OutLast    = last_q;
  assign ArrayClear = clear_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain (COLS=4, WIDTH=8, ACCUMULATOR_WIDTH=32).
module tb_result_drain;

  logic         CLK;
  logic         SYNC_RST;
  logic         Capture;
  logic [127:0] Results;
  logic [4:0]   Shift;
  logic         OutReady;
  logic         OutValid;
  logic [7:0]   OutData;
  logic [1:0]   OutIndex;
  logic         OutLast;
  logic         ArrayClear;
  logic         Busy;
  logic         Overrun;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   xfers  = 0;

  result_drain #(.COLS(4), .WIDTH(8), .ACCUMULATOR_WIDTH(32)) dut (
    .CLK(CLK), .SYNC_RST(SYNC_RST), .Capture(Capture), .Results(Results),
    .Shift(Shift), .OutReady(OutReady), .OutValid(OutValid), .OutData(OutData),
    .OutIndex(OutIndex), .OutLast(OutLast), .ArrayClear(ArrayClear),
    .Busy(Busy), .Overrun(Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] rq(input logic [31:0] v, input logic [4:0] sh);
    logic [31:0] s;
    s = v >> sh;
    return (s > 32'd255) ? 8'hFF : s[7:0];
  endfunction

  // Transfers seen mid-cycle complete at the following rising edge.
  always @(negedge CLK) begin
    if (SYNC_RST === 1'b0 && OutValid === 1'b1 && OutReady === 1'b1) begin
      xfers++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got data=%0h idx=%0d last=%0b, required no transfer",
                 OutData, OutIndex, OutLast);
      end else begin
        e = sb.pop_front();
        if ({OutData, OutIndex, OutLast} !== e) begin
          errors++;
          $display("FAIL xfer: got data=%0h idx=%0d last=%0b, required data=%0h idx=%0d last=%0b",
                   OutData, OutIndex, OutLast, e.data, e.idx, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_capture(input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3,
                            input logic [4:0] sh, input bit expect_accept);
    logic [31:0] r [4];
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    Results = {r3, r2, r1, r0};
    Shift   = sh;
    Capture = 1'b1;
    if (expect_accept)
      for (int c = 0; c < 4; c++) sb.push_back('{rq(r[c], sh), 2'(c), (c == 3)});
  endtask

  task automatic test_reset();
    SYNC_RST = 1'b1;
    OutReady = 1'b1;
    do_capture(32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b0);
    tick();
    tick();
    checks++;
    if ({OutValid, OutData, OutIndex, OutLast, ArrayClear, Busy, Overrun} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {OutValid, OutData, OutIndex, OutLast, ArrayClear, Busy, Overrun});
    end
    SYNC_RST = 1'b0;
    Capture  = 1'b0;
    tick();
    checks++;
    if (ArrayClear !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_clear: got clear=%b busy=%b, required 0 0", ArrayClear, Busy);
    end
  endtask

  task automatic test_basic();
    OutReady = 1'b1;
    do_capture(32'd10, 32'd20, 32'd30, 32'd40, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (ArrayClear !== (k == 1) || OutLast !== (k == 4) ||
          OutValid !== (k <= 4) || Busy !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_ctrl c%0d: got clear=%b last=%b valid=%b busy=%b, required %b %b %b %b",
                 k, ArrayClear, OutLast, OutValid, Busy, k == 1, k == 4, k <= 4, k <= 4);
      end
      if (k <= 4) begin
        checks++;
        if (OutIndex !== 2'(k - 1)) begin
          errors++;
          $display("FAIL basic_index c%0d: got %0d, required %0d", k, OutIndex, k - 1);
        end
      end
      if (k < 5) tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drained: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_shift_sat();
    OutReady = 1'b1;
    do_capture(32'h300, 32'h400, 32'hFFFF_FFFF, 32'h0, 5'd2, 1'b1);
    tick();
    Capture = 1'b0;
    Shift   = 5'd31;
    run(4);
    do_capture(32'h300, 32'h400, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b1);
    tick();
    Capture = 1'b0;
    Shift   = 5'd0;
    run(4);
    checks++;
    if (sb.size() != 0 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL shift_drained: got pending=%0d valid=%b, required 0 0", sb.size(), OutValid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    logic [7:0] pd;
    logic [1:0] pi;
    int         x0;
    pat = 8'b1011_0100;
    OutReady = 1'b0;
    x0 = xfers;
    do_capture(32'h11, 32'h22, 32'h133, 32'h44, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    pd = 8'h00;
    pi = 2'd0;
    for (int i = 0; i < 8; i++) begin
      OutReady = pat[i];
      checks++;
      if (OutValid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid c%0d: got %b, required 1", i, OutValid);
      end
      if (i > 0 && pat[i-1] == 1'b0) begin
        checks++;
        if (OutData !== pd || OutIndex !== pi) begin
          errors++;
          $display("FAIL bp_stable c%0d: got data=%0h idx=%0d, required data=%0h idx=%0d",
                   i, OutData, OutIndex, pd, pi);
        end
      end
      pd = OutData;
      pi = OutIndex;
      tick();
    end
    OutReady = 1'b1;
    checks++;
    if (xfers - x0 != 4 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got xfers=%0d valid=%b, required 4 0", xfers - x0, OutValid);
    end
  endtask

  task automatic test_overrun_b2b();
    OutReady = 1'b1;
    do_capture(32'h50, 32'h60, 32'h70, 32'h80, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    tick();
    checks++;
    if (OutIndex !== 2'd1) begin
      errors++;
      $display("FAIL ovr_setup: got idx=%0d, required 1", OutIndex);
    end
    do_capture(32'h9, 32'h9, 32'h9, 32'h9, 5'd0, 1'b0);
    tick();
    Capture = 1'b0;
    checks++;
    if (Overrun !== 1'b1 || ArrayClear !== 1'b0 || OutIndex !== 2'd2) begin
      errors++;
      $display("FAIL ovr_ignored: got ovr=%b clear=%b idx=%0d, required 1 0 2",
               Overrun, ArrayClear, OutIndex);
    end
    run(2);
    checks++;
    if (Overrun !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_sticky: got ovr=%b valid=%b, required 1 0", Overrun, OutValid);
    end
    SYNC_RST = 1'b1;
    tick();
    SYNC_RST = 1'b0;
    checks++;
    if (Overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_reset: got %b, required 0", Overrun);
    end
    do_capture(32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    run(3);
    checks++;
    if (OutLast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last: got %b, required 1", OutLast);
    end
    do_capture(32'd5, 32'd6, 32'd7, 32'd8, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || OutIndex !== 2'd0 || ArrayClear !== 1'b1 ||
        Overrun !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: got valid=%b idx=%0d clear=%b ovr=%b busy=%b, required 1 0 1 0 1",
               OutValid, OutIndex, ArrayClear, Overrun, Busy);
    end
    run(4);
    checks++;
    if (sb.size() != 0 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: got pending=%0d valid=%b, required 0 0", sb.size(), OutValid);
    end
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b1;
    do_capture(32'hA, 32'hB, 32'hC, 32'hD, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    run(2);
    checks++;
    if (OutIndex !== 2'd2) begin
      errors++;
      $display("FAIL rmid_setup: got idx=%0d, required 2", OutIndex);
    end
    SYNC_RST = 1'b1;
    OutReady = 1'b0;
    tick();
    SYNC_RST = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || Busy !== 1'b0 || ArrayClear !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort: got valid=%b busy=%b clear=%b, required 0 0 0",
               OutValid, Busy, ArrayClear);
    end
    sb.delete();
    OutReady = 1'b1;
    do_capture(32'h21, 32'h22, 32'h23, 32'h24, 5'd0, 1'b1);
    tick();
    Capture = 1'b0;
    checks++;
    if (OutIndex !== 2'd0 || ArrayClear !== 1'b1 || OutValid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: got idx=%0d clear=%b valid=%b, required 0 1 1",
               OutIndex, ArrayClear, OutValid);
    end
    run(4);
    checks++;
    if (sb.size() != 0 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_drained: got pending=%0d valid=%b, required 0 0", sb.size(), OutValid);
    end
  endtask

  initial begin
    SYNC_RST = 1'b1;
    Capture  = 1'b0;
    Results  = '0;
    Shift    = '0;
    OutReady = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_shift_sat();
    test_backpressure();
    test_overrun_b2b();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Output-side reader for a row of systolic `Processing_Element` accumulators. On a capture pulse it snapshots all `COLS` accumulator values into a shadow buffer and pulses a clear to the array, so the array can start the next tile. It then requantizes each value with a logical right shift and unsigned saturation to `WIDTH` bits, and streams the values out one per handshake over a valid/ready port. It sits between the PE array's `Result` outputs and the downstream output buffer/DMA.

## Interface
- `COLS`, default 4: number of PE columns drained per capture.
- `WIDTH`, default 8: output element width.
- `ACCUMULATOR_WIDTH`, default 32: width of each PE `Result`.
- `CLK`  in  1: the only clock; all logic is rising-edge.
- `SYNC_RST`  in  1: synchronous, active-high reset; sampled on the `CLK` rising edge.
- `Capture`  in  1: single-cycle request to snapshot `Results`.
- `Results`  in  `COLS*ACCUMULATOR_WIDTH`: column c is `Results[c*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH]`.
- `Shift`  in  `$clog2(ACCUMULATOR_WIDTH)`: right-shift amount, latched at capture.
- `OutReady`  in  1: downstream can accept data.
- `OutValid`  out  1: `OutData` is valid.
- `OutData`  out  `WIDTH`: requantized element.
- `OutIndex`  out  `max(1,$clog2(COLS))`: column index of `OutData`.
- `OutLast`  out  1: high with the element of column `COLS-1`.
- `ArrayClear`  out  1: one-cycle pulse that drives the PE array `SYNC_RST`.
- `Busy`  out  1: high while streaming.
- `Overrun`  out  1: sticky flag, set when a capture is dropped.

## Operation
- FSM states: IDLE and STREAM. `Busy` is high exactly when the FSM is in STREAM.
- Capture is accepted when `Capture`=1 and either:
  - the FSM is in IDLE, or
  - the final handshake occurs this cycle (`OutValid & OutReady & OutLast`), which gives back-to-back acceptance.
- On acceptance:
  - All `COLS` `Results` are registered into the shadow buffer.
  - `Shift` is latched.
  - The element index resets to 0 and the FSM goes to (or stays in) STREAM.
  - `ArrayClear` is 1 on the next cycle only.
- `Capture` in STREAM without the final handshake is ignored: the buffer, index and stream are unchanged, and `Overrun` is set to 1.
  - `Overrun` stays set until `SYNC_RST`.
- Requantization per element:
  - `s = buf[i] >> Shift_latched` (logical shift, operands unsigned).
  - `OutData = (s > 2^WIDTH-1) ? {WIDTH{1'b1}} : s[WIDTH-1:0]`.
- `OutData`, `OutIndex` and `OutLast` are registered; they are loaded for element 0 on acceptance and for element i+1 on each handshake.
- Transfer rule: a transfer occurs on a rising edge with `OutValid`=1 and `OutReady`=1.
  - While `OutValid`=1 and `OutReady`=0, `OutData`, `OutIndex` and `OutLast` hold stable.
  - `OutValid` never drops before its transfer.
- After the transfer with `OutLast`=1 and no simultaneous accepted capture, the next cycle has `OutValid`=0, `OutLast`=0, `Busy`=0 and state IDLE.
- `Results` may change freely after the capture cycle; only the shadow copy is streamed.

## Timing
- Reset (`SYNC_RST`=1 at an edge):
  - State goes to IDLE.
  - `OutValid`, `OutData`, `OutIndex`, `OutLast`, `ArrayClear`, `Busy` and `Overrun` all go to 0.
  - The buffer contents are don't-care.
  - `SYNC_RST` has priority over `Capture` and handshakes.
- Reset mid-stream aborts the stream. No `ArrayClear` pulse is generated by reset.
- Capture latency: capture accepted at edge t gives `OutValid`=1, `OutIndex`=0 and `ArrayClear`=1 during cycle t+1.
- Throughput: with `OutReady` held at 1, one element per cycle, so `COLS` cycles per capture.
- Back-to-back: a capture accepted on the last-handshake edge gives `OutValid` continuously high, with the new column 0 in the next cycle and `Overrun` unchanged.
- Minimum capture spacing without loss: `COLS` cycles when `OutReady`=1.
- `COLS`=1: every element has `OutLast`=1.

## Test plan
Directed scenarios use `COLS`=4, `WIDTH`=8 and `ACCUMULATOR_WIDTH`=32.

- **Reset priority.** `SYNC_RST`=1 for 2 cycles with `Capture`=1 -> all outputs 0, no `ArrayClear`, `Busy`=0.
- **Basic stream.** `Results`={10,20,30,40}, `Shift`=0, `OutReady`=1, `Capture` pulse at edge t ->
  - `ArrayClear`=1 only in t+1;
  - `OutData` 10,20,30,40 with `OutIndex` 0..3 in t+1..t+4;
  - `OutLast`=1 only in t+4;
  - `OutValid` and `Busy` drop to 0 in t+5.
- **Shift and saturation.** `Results`={0x300, 0x400, 0xFFFFFFFF, 0} with `Shift`=2 -> `OutData` 0xC0, 0xFF, 0xFF, 0x00.
  - Repeat with `Shift`=31 -> 0x00, 0x00, 0x01, 0x00.
  - Changing `Shift` mid-stream has no effect on the current stream.
- **Backpressure.** `OutReady` pattern 0,0,1,0,1,1,0,1 -> exactly 4 transfers, in order; data and index held stable during every stall; `OutValid` stays high until the 4th transfer.
- **Overrun and back-to-back.**
  - `Capture` while `OutIndex`=1 -> ignored; stream continues unchanged; `Overrun`=1 and sticky.
  - After reset: a second `Capture` with `Results`={5,6,7,8} on the last-handshake edge -> `OutValid` stays high, next `OutData`=5 with `OutIndex`=0, `ArrayClear` pulses again, `Overrun` stays 0.
- **Reset mid-stream.** `SYNC_RST` asserted at `OutIndex`=2 -> next cycle `OutValid`=0, IDLE; a fresh `Capture` then streams its new values from index 0.
